// File: rtl/axis_packet_generator.sv
// axis_packet_generator: register-programmed AXI-Stream burst source
// with deterministic payload, boundary-safe abort and done interrupt.
module axis_packet_generator #(
  parameter int LEN_WIDTH = 11,
  parameter int GAP_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic [15:0] tx_tdata,
  output logic        tx_tvalid,
  output logic        tx_tlast,
  input  logic        tx_tready,
  output logic        irq
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_LEN_LO = 8'h01;
  localparam logic [7:0] A_LEN_HI = 8'h02;
  localparam logic [7:0] A_NUM    = 8'h03;
  localparam logic [7:0] A_GAP    = 8'h04;
  localparam logic [7:0] A_SEED   = 8'h05;
  localparam logic [7:0] A_STATUS = 8'h06;
  localparam logic [7:0] A_SENT   = 8'h07;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t state;

  logic                 irq_en;
  logic                 abort_pend;
  logic                 done;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [7:0]           num_pkts;
  logic [GAP_WIDTH-1:0] gap_reg;
  logic [7:0]           seed;
  logic [LEN_WIDTH-1:0] word;
  logic [7:0]           pkt;
  logic [7:0]           sent;
  logic [GAP_WIDTH-1:0] gap_cnt;

  logic                 wr;
  logic                 busy;
  logic                 ctrl_wr;
  logic                 start_wr;
  logic                 abort_wr;
  logic                 clr_done;
  logic                 abort_now;
  logic                 end_burst;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [LEN_WIDTH-1:0] len_last;
  logic [LEN_WIDTH-1:0] word_nxt;
  logic [7:0]           pkt_nxt;

  function automatic logic [15:0] beat(
    input logic [7:0]           p,
    input logic [LEN_WIDTH-1:0] w,
    input logic [7:0]           s
  );
    return {p, w[7:0] ^ s};
  endfunction

  assign wr        = chipselect & write;
  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = wr & (address == A_CTRL);
  assign start_wr  = ctrl_wr & writedata[0];
  assign abort_wr  = ctrl_wr & writedata[2];
  assign clr_done  = wr & (address == A_STATUS) & writedata[1];
  assign abort_now = abort_pend | abort_wr;

  assign len_eff   = (len_reg == '0) ? LEN_WIDTH'(1) : len_reg;
  assign len_last  = len_eff - LEN_WIDTH'(1);
  assign word_nxt  = word + LEN_WIDTH'(1);
  assign pkt_nxt   = pkt + 8'd1;
  assign end_burst = (pkt_nxt == num_pkts) | abort_now;

  assign irq = done & irq_en;

  // Burst parameters are frozen while busy so a running burst is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en   <= 1'b0;
      len_reg  <= '0;
      num_pkts <= '0;
      gap_reg  <= '0;
      seed     <= '0;
    end else if (wr) begin
      case (address)
        A_CTRL:   irq_en <= writedata[1];
        A_LEN_LO: if (!busy) len_reg[7:0] <= writedata;
        A_LEN_HI: if (!busy) len_reg[LEN_WIDTH-1:8] <= writedata[LEN_WIDTH-9:0];
        A_NUM:    if (!busy) num_pkts <= writedata;
        A_GAP:    if (!busy) gap_reg <= writedata[GAP_WIDTH-1:0];
        A_SEED:   if (!busy) seed <= writedata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      word       <= '0;
      pkt        <= '0;
      sent       <= '0;
      gap_cnt    <= '0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
      tx_tvalid  <= 1'b0;
      tx_tlast   <= 1'b0;
      tx_tdata   <= '0;
    end else begin
      if (clr_done) done <= 1'b0;
      if (abort_wr && busy) abort_pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start_wr) begin
            sent <= '0;
            if (num_pkts == 8'd0) begin
              done <= 1'b1;
            end else begin
              state     <= S_SEND;
              done      <= 1'b0;
              word      <= '0;
              pkt       <= '0;
              tx_tvalid <= 1'b1;
              tx_tdata  <= beat(8'd0, '0, seed);
              tx_tlast  <= (len_last == '0);
            end
          end
        end
        S_SEND: begin
          if (tx_tready) begin
            if (!tx_tlast) begin
              word     <= word_nxt;
              tx_tdata <= beat(pkt, word_nxt, seed);
              tx_tlast <= (word_nxt == len_last);
            end else begin
              sent <= sent + 8'd1;
              pkt  <= pkt_nxt;
              word <= '0;
              if (end_burst) begin
                state      <= S_IDLE;
                done       <= 1'b1;
                abort_pend <= 1'b0;
                tx_tvalid  <= 1'b0;
                tx_tlast   <= 1'b0;
              end else if (gap_reg == '0) begin
                tx_tdata <= beat(pkt_nxt, '0, seed);
                tx_tlast <= (len_last == '0);
              end else begin
                state     <= S_GAP;
                gap_cnt   <= gap_reg - GAP_WIDTH'(1);
                tx_tvalid <= 1'b0;
                tx_tlast  <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          if (abort_now) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= S_SEND;
            tx_tvalid <= 1'b1;
            tx_tdata  <= beat(pkt, '0, seed);
            tx_tlast  <= (len_last == '0);
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      case (address)
        A_CTRL:   readdata <= {5'b0, abort_pend, irq_en, busy};
        A_LEN_LO: readdata <= len_reg[7:0];
        A_LEN_HI: readdata <= 8'(len_reg[LEN_WIDTH-1:8]);
        A_NUM:    readdata <= num_pkts;
        A_GAP:    readdata <= 8'(gap_reg);
        A_SEED:   readdata <= seed;
        A_STATUS: readdata <= {6'b0, done, busy};
        A_SENT:   readdata <= sent;
        default:  readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_generator.sv
// tb_axis_packet_generator: randomized bench with a beat-list model
// of the packet generator's burst output and register map.
module tb_axis_packet_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [15:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic        tx_tready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          got_cyc[$];
  int          stab_viol;

  axis_packet_generator dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .tx_tdata   (tx_tdata),
    .tx_tvalid  (tx_tvalid),
    .tx_tlast   (tx_tlast),
    .tx_tready  (tx_tready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference: packet p, word w carries {p, w^seed}; last word of each packet flagged.
  function automatic void build_model(input int len, input int npk, input logic [7:0] seed);
    int eff;
    logic [7:0] p8;
    logic [7:0] w8;
    eff = (len == 0) ? 1 : len;
    exp_q.delete();
    for (int p = 0; p < npk; p++) begin
      for (int w = 0; w < eff; w++) begin
        p8 = 8'(p);
        w8 = 8'(w);
        exp_q.push_back({(w == eff - 1), p8, w8 ^ seed});
      end
    end
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic configure(input int len, input int num, input int gap, input logic [7:0] seed);
    bus_write(8'h01, 8'(len));
    bus_write(8'h02, 8'(len >> 8));
    bus_write(8'h03, 8'(num));
    bus_write(8'h04, 8'(gap));
    bus_write(8'h05, seed);
  endtask

  task automatic collect(input int n_exp, input int pct, input int abort_after, input int limit);
    int cyc;
    int idle_after;
    bit prev_stall;
    bit abort_sent;
    logic [16:0] prev;
    cyc = 0; idle_after = 0; prev_stall = 0; abort_sent = 0; prev = '0;
    got_q.delete(); got_cyc.delete(); stab_viol = 0;
    while (cyc < limit && idle_after < 20) begin
      tx_tready = ($urandom_range(99) < pct);
      if (abort_after >= 0 && got_q.size() == abort_after && !abort_sent) begin
        chipselect = 1'b1; write = 1'b1; address = 8'h00; writedata = 8'h04;
        abort_sent = 1;
      end else begin
        chipselect = 1'b0; write = 1'b0;
      end
      @(negedge clk);
      if (prev_stall && (!tx_tvalid || {tx_tlast, tx_tdata} !== prev)) stab_viol++;
      prev_stall = tx_tvalid && !tx_tready;
      prev = {tx_tlast, tx_tdata};
      if (tx_tvalid && tx_tready) begin
        got_q.push_back({tx_tlast, tx_tdata});
        got_cyc.push_back(cyc);
      end
      if (got_q.size() >= n_exp) idle_after++;
      @(posedge clk); #1;
      cyc++;
    end
    chipselect = 1'b0; write = 1'b0; tx_tready = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tdata, irq, readdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h irq=%b rd=%h, expected all 0",
               tx_tvalid, tx_tlast, tx_tdata, irq, readdata);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(8'(a), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, expected 00", a, d);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] d;
    configure(4, 2, 0, 8'h00);
    bus_write(8'h00, 8'h01);
    checks++;
    if (tx_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: tvalid=%b one cycle after start, expected 1", tx_tvalid);
    end
    collect(8, 100, -1, 200);
    build_model(4, 2, 8'h00);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 8) begin
      checks++;
      if (got_cyc[7] - got_cyc[0] !== 7) begin
        errors++;
        $display("FAIL basic_b2b: span %0d cycles, expected 7", got_cyc[7] - got_cyc[0]);
      end
    end
    bus_read(8'h07, d);
    checks++;
    if (d !== 8'd2) begin
      errors++;
      $display("FAIL basic_sent: got %0d, expected 2", d);
    end
    bus_read(8'h06, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL basic_status: got %h, expected 02", d);
    end
    bus_read(8'h20, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL unmapped_read: got %h, expected 00", d);
    end
  endtask

  task automatic test_gap;
    logic [7:0] seed;
    seed = 8'($urandom);
    configure(3, 2, 5, seed);
    bus_write(8'h00, 8'h01);
    collect(6, 100, -1, 200);
    build_model(3, 2, seed);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL gap_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 6) begin
      checks++;
      if (got_cyc[3] - got_cyc[2] - 1 !== 5) begin
        errors++;
        $display("FAIL gap_idle: got %0d idle cycles, expected 5", got_cyc[3] - got_cyc[2] - 1);
      end
    end
  endtask

  task automatic test_random_ready;
    logic [7:0] d;
    int len, num, gap;
    logic [7:0] seed;
    for (int it = 0; it < 4; it++) begin
      len  = (it == 0) ? 0 : (it == 3) ? 300 : int'($urandom_range(1, 12));
      num  = (it == 3) ? 2 : int'($urandom_range(1, 4));
      gap  = int'($urandom_range(0, 3));
      seed = 8'($urandom);
      configure(len, num, gap, seed);
      build_model(len, num, seed);
      bus_write(8'h00, 8'h01);
      collect(exp_q.size(), 50, -1, exp_q.size() * 4 + 200);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d beats, expected %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: got %h, expected %h", it, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stab_viol !== 0) begin
        errors++;
        $display("FAIL rand%0d_stable: %0d stall violations, expected 0", it, stab_viol);
      end
      bus_read(8'h07, d);
      checks++;
      if (d !== 8'(num)) begin
        errors++;
        $display("FAIL rand%0d_sent: got %0d, expected %0d", it, d, num);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] d;
    int abort_after, pkts;
    abort_after = 19;
    pkts = abort_after / 8 + 1;
    configure(8, 10, 0, 8'h00);
    bus_write(8'h00, 8'h01);
    collect(pkts * 8, 100, abort_after, 500);
    build_model(8, pkts, 8'h00);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_beat%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
      end
    end
    bus_read(8'h07, d);
    checks++;
    if (d !== 8'(pkts)) begin
      errors++;
      $display("FAIL abort_sent: got %0d, expected %0d", d, pkts);
    end
    bus_read(8'h06, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL abort_status: got %h, expected 02", d);
    end
    bus_write(8'h00, 8'h04);
    bus_read(8'h00, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL abort_idle: ctrl got %h, expected 00", d);
    end
  endtask

  task automatic test_irq_busy_write;
    logic [7:0] d;
    bus_write(8'h06, 8'h02);
    bus_write(8'h00, 8'h02);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: got %b, expected 0", irq);
    end
    configure(5, 2, 2, 8'h3c);
    tx_tready = 1'b0;
    bus_write(8'h00, 8'h03);
    bus_write(8'h01, 8'h09);
    bus_read(8'h01, d);
    checks++;
    if (d !== 8'h05) begin
      errors++;
      $display("FAIL busy_len_write: got %h, expected 05", d);
    end
    bus_read(8'h06, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL busy_status: got %h, expected 01", d);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tdata} !== {1'b1, 1'b0, 16'h003c}) begin
      errors++;
      $display("FAIL stall_hold: got v=%b l=%b d=%h, expected v=1 l=0 d=003c",
               tx_tvalid, tx_tlast, tx_tdata);
    end
    checks++;
    if (readdata !== 8'h01) begin
      errors++;
      $display("FAIL readdata_hold: got %h, expected 01", readdata);
    end
    collect(10, 100, -1, 200);
    build_model(5, 2, 8'h3c);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL irq_count: got %0d beats, expected %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b, expected 1", irq);
    end
    bus_write(8'h06, 8'h02);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b, expected 0", irq);
    end
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] d;
    configure(6, 3, 0, 8'h11);
    bus_read(8'h01, d);
    tx_tready = 1'b1;
    bus_write(8'h00, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tdata, irq, readdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b l=%b d=%h irq=%b rd=%h, expected all 0",
               tx_tvalid, tx_tlast, tx_tdata, irq, readdata);
    end
    reset = 1'b0;
    bus_read(8'h01, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL midreset_len: got %h, expected 00", d);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL midreset_ctrl: got %h, expected 00", d);
    end
  endtask

  task automatic test_num_zero;
    logic [7:0] d;
    bus_write(8'h01, 8'h04);
    bus_write(8'h00, 8'h01);
    collect(0, 100, -1, 100);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL numzero_beats: got %0d beats, expected 0", got_q.size());
    end
    bus_read(8'h06, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL numzero_status: got %h, expected 02", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; tx_tready = 1'b1;
    test_reset();
    test_basic();
    test_gap();
    test_random_ready();
    test_abort();
    test_irq_busy_write();
    test_reset_mid_packet();
    test_num_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
